// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared types and constants for the piso_tx transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    // Default serial word length.
    localparam int PISO_WIDTH = 4;

    // Transmitter FSM encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } piso_state_e;

endpackage : piso_pkg
`default_nettype wire

// File: rtl/bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : bit_counter
// Description : Bit-position counter with synchronous clear, enable and a
//               terminal-count flag at WIDTH-1. Asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_counter
    import piso_pkg::*;
#(
    parameter  int WIDTH = PISO_WIDTH,
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          sclr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    localparam logic [CW-1:0] C_TERMINAL = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (sclr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == C_TERMINAL);

endmodule : bit_counter
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx
// Description : Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word
//               over valid/ready and emits it one bit per enabled clock with
//               a valid strobe and last-bit marker. Words can stream
//               back-to-back; shift_en low freezes the stream.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx
    import piso_pkg::*;
#(
    parameter  int WIDTH     = PISO_WIDTH,
    parameter  int MSB_FIRST = 1,
    localparam int CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    output logic             d_out,
    output logic             d_valid,
    output logic             last
);

    piso_state_e      state_q;
    piso_state_e      state_d;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_d;

    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic [CW-1:0]    w_cnt;
    logic             w_tc;
    logic [WIDTH-1:0] w_order;   // holding word rearranged so index = send position

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .clr    (clr),
        .sclr_i (w_cnt_clr),
        .en_i   (w_cnt_en),
        .cnt_o  (w_cnt),
        .tc_o   (w_tc)
    );

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            for (genvar i = 0; i < WIDTH; i++) begin : g_rev
                assign w_order[i] = hold_q[WIDTH-1-i];
            end
        end else begin : g_lsb_first
            assign w_order = hold_q;
        end
    endgenerate

    // Next-state, holding-register, counter-control and output decode.
    // Outputs never look at load_valid, so the handshake has no comb loop.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        w_cnt_clr  = 1'b0;
        w_cnt_en   = 1'b0;
        d_out      = 1'b0;
        d_valid    = 1'b0;
        last       = 1'b0;
        load_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_ready = clr;
                if (load_valid && clr) begin
                    hold_d    = data_in;
                    w_cnt_clr = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                d_out      = w_order[w_cnt];
                d_valid    = shift_en;
                last       = w_tc & shift_en;
                load_ready = clr & w_tc & shift_en;
                if (shift_en) begin
                    if (w_tc) begin
                        w_cnt_clr = 1'b1;
                        if (load_valid) begin
                            hold_d = data_in;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and holding registers; reset aborts any word in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

endmodule : piso_tx
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx
// Description : Self-checking bench for piso_tx. Two instances (MSB-first and
//               LSB-first) share stimulus; a bit-queue model predicts every
//               output on every cycle, and directed traces pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       load_valid = 1'b0;
    logic       shift_en = 1'b0;
    logic [3:0] data_in = 4'h0;

    logic rdy_m, d_m, v_m, l_m;
    logic rdy_l, d_l, v_l, l_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
        .clk        (clk),
        .clr        (clr),
        .load_valid (load_valid),
        .load_ready (rdy_m),
        .data_in    (data_in),
        .shift_en   (shift_en),
        .d_out      (d_m),
        .d_valid    (v_m),
        .last       (l_m)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
        .clk        (clk),
        .clr        (clr),
        .load_valid (load_valid),
        .load_ready (rdy_l),
        .data_in    (data_in),
        .shift_en   (shift_en),
        .d_out      (d_l),
        .d_valid    (v_l),
        .last       (l_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bits still to be sent, in send order, for each instance.
    logic q_m[$];
    logic q_l[$];
    logic mdl_last;
    logic mdl_hs;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_m.delete();
            q_l.delete();
        end else begin
            mdl_last = (q_m.size() == 1) && shift_en;
            mdl_hs   = load_valid && ((q_m.size() == 0) || mdl_last);
            if ((q_m.size() > 0) && shift_en) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            if (mdl_hs) begin
                for (int i = 0; i < 4; i++) begin
                    q_m.push_back(data_in[3-i]);
                    q_l.push_back(data_in[i]);
                end
            end
        end
    end

    task automatic cmp_one(input string tag, input logic q[$],
                           input logic rdy, input logic d, input logic v, input logic l);
        logic e_d, e_v, e_l, e_r;
        e_d = (q.size() > 0) ? q[0] : 1'b0;
        e_v = (q.size() > 0) && shift_en;
        e_l = (q.size() == 1) && shift_en;
        e_r = clr && ((q.size() == 0) || e_l);
        chk({tag, "_d_out"},      d,   e_d);
        chk({tag, "_d_valid"},    v,   e_v);
        chk({tag, "_last"},       l,   e_l);
        chk({tag, "_load_ready"}, rdy, e_r);
    endtask

    // Per-cycle traces for directed expectations.
    logic tr_d[$], tr_v[$], tr_l[$], tr_r[$], tr_dl[$];

    always @(negedge clk) begin
        cmp_one("msb", q_m, rdy_m, d_m, v_m, l_m);
        cmp_one("lsb", q_l, rdy_l, d_l, v_l, l_l);
        tr_d.push_back(d_m);
        tr_v.push_back(v_m);
        tr_l.push_back(l_m);
        tr_r.push_back(rdy_m);
        tr_dl.push_back(d_l);
    end

    // Downstream 4-bit shift register fed by the MSB-first instance.
    logic [3:0] q_ds = 4'h0;
    always @(posedge clk) begin
        if (v_m) q_ds <= {q_ds[2:0], d_m};
    end

    function automatic logic [31:0] pack(input logic q[$], input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r = {r[30:0], (i < q.size()) ? q[i] : 1'bx};
        end
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_tr();
        tr_d.delete(); tr_v.delete(); tr_l.delete(); tr_r.delete(); tr_dl.delete();
    endtask

    initial begin
        clr = 1'b0; load_valid = 1'b1; data_in = 4'hF; shift_en = 1'b1;
        #12;
        chk("rst_load_ready", rdy_m, 1'b0);
        chk("rst_outputs", {d_m, v_m, l_m}, 3'b000);
        #9;
        clr = 1'b1; load_valid = 1'b0;
        #9;
        chk("ready_after_release", rdy_m, 1'b1);
        cyc(1);

        // Single word 1011.
        data_in = 4'b1011; load_valid = 1'b1;
        cyc(1); clr_tr(); load_valid = 1'b0;
        cyc(6);
        chk("single_bits",   pack(tr_d, 4), 4'b1011);
        chk("single_valid",  pack(tr_v, 5), 5'b11110);
        chk("single_last",   pack(tr_l, 5), 5'b00010);
        chk("single_ready",  pack(tr_r, 5), 5'b00011);
        chk("single_ds_q",   q_ds, 4'b1011);

        // Back-to-back 1100 then 0110.
        data_in = 4'b1100; load_valid = 1'b1;
        cyc(1); clr_tr(); data_in = 4'b0110;
        cyc(4); load_valid = 1'b0;
        cyc(6);
        chk("b2b_bits",  pack(tr_d, 8), 8'b11000110);
        chk("b2b_valid", pack(tr_v, 9), 9'b111111110);
        chk("b2b_ready", pack(tr_r, 8), 8'b00010001);
        chk("b2b_ds_q",  q_ds, 4'b0110);

        // Stall of 3 cycles after bit 2 of 1001.
        data_in = 4'b1001; load_valid = 1'b1;
        cyc(1); clr_tr(); load_valid = 1'b0;
        cyc(2); shift_en = 1'b0;
        cyc(3); shift_en = 1'b1;
        cyc(5);
        chk("stall_bits",  pack(tr_d, 7), 7'b1000001);
        chk("stall_valid", pack(tr_v, 8), 8'b11000110);
        chk("stall_last",  pack(tr_l, 8), 8'b00000010);
        chk("stall_ready", pack(tr_r, 8), 8'b00000011);
        chk("stall_ds_q",  q_ds, 4'b1001);

        // Stall on the last bit while a new word waits.
        data_in = 4'b0101; load_valid = 1'b1;
        cyc(1); clr_tr(); load_valid = 1'b0;
        cyc(3); shift_en = 1'b0; load_valid = 1'b1; data_in = 4'b1110;
        cyc(2); shift_en = 1'b1;
        cyc(1); load_valid = 1'b0;
        cyc(6);
        chk("laststall_bits",  pack(tr_d, 10),  10'b0101111110);
        chk("laststall_ready", pack(tr_r, 10),  10'b0000010001);
        chk("laststall_lsb",   pack(tr_dl, 10), 10'b1010000111);

        // LSB-first instance with 0001.
        data_in = 4'b0001; load_valid = 1'b1;
        cyc(1); clr_tr(); load_valid = 1'b0;
        cyc(5);
        chk("lsb_bits", pack(tr_dl, 4), 4'b1000);
        chk("lsb_msb_inst_bits", pack(tr_d, 4), 4'b0001);

        // Reset mid-word.
        data_in = 4'b1111; load_valid = 1'b1;
        cyc(1); load_valid = 1'b0;
        cyc(2);
        clr = 1'b0;
        #1;
        chk("midrst_outputs", {d_m, v_m, l_m, rdy_m}, 4'b0000);
        chk("midrst_lsb_outputs", {d_l, v_l, l_l, rdy_l}, 4'b0000);
        cyc(2);
        clr = 1'b1; clr_tr();
        cyc(6);
        chk("midrst_no_residual", pack(tr_v, 6), 6'b000000);
        chk("midrst_ready",       pack(tr_r, 6), 6'b111111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_piso_tx
`default_nettype wire
